multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Parametrised multicycle control unit for the MIPS datapath. It replaces purely combinational opcode/funct decoding with a state machine that sequences every instruction through fetch, decode, execute, memory and write-back. Memory accesses use a ready handshake, and the unit keeps an instruction-retire counter. It sits between the instruction register and the datapath multiplexers, register file, ALU and unified instruction/data memory.

## Interface
- ALU_CTRL_W, 4: width of alu_control.
- CNT_W, 32: width of instr_count.
- ENABLE_JAL, 1: 1 = jal supported; 0 = jal (0x03) decoded as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back data from memory.
- reg_write  out  1  register file write enable.
- link  out  1  write PC to $31 (jal).
- alu_src_a  out  2  0 = PC, 1 = A register, 2 = zero-extended shamt.
- alu_src_b  out  2  0 = B register, 1 = constant 4, 2 = extended imm, 3 = sign-extended imm<<2.
- ext_zero  out  1  1 = zero-extend imm (andi, ori); 0 = sign-extend.
- alu_control  out  ALU_CTRL_W  ALU codes: 2 add, 3 sub, 5 and, 6 or, 8 sll, 12 lui.
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
- retire  out  1  one-cycle pulse when an instruction completes.
- state  out  4  current state code, for debug.
- instr_count  out  CNT_W  retired-instruction counter.

## Operation
- State codes: RESET 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXEC_R 7, EXEC_I 8, ALU_WB 9, BRANCH 10, JUMP 11.
- Every output not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_control=2.
  - Drives ir_write=pc_write=mem_ready and pc_src=0.
  - Holds until mem_ready=1, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_control=2 (computes the branch target).
  - Registers the instruction class and reg_dst flag.
  - R-type (opcode 0) with funct in {0x00, 0x20, 0x25, 0x22} goes to EXEC_R.
  - 0x23 and 0x2B go to MEM_ADDR.
  - 0x08, 0x0C, 0x0D, 0x0F go to EXEC_I.
  - 0x04 and 0x05 go to BRANCH.
  - 0x02 goes to JUMP; 0x03 goes to JUMP when ENABLE_JAL=1.
  - Anything else pulses illegal and retire, then goes to FETCH (executed as a nop).
- EXEC_R: alu_src_a=1, except sll uses 2; alu_src_b=0. alu_control: sll 8, add 2, sub 3, or 6. Next state is ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=2. alu_control: addi 2, andi 5 with ext_zero=1, ori 6 with ext_zero=1, lui 12. Next state is ALU_WB.
- ALU_WB: reg_write=1, reg_dst=registered flag (1 for R-type, 0 for I-type). Pulses retire, then goes to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_control=2. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, iord=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Pulses retire, then goes to FETCH.
- MEM_WRITE: mem_write=1, iord=1. Holds until mem_ready; on mem_ready pulses retire and goes to FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=0, alu_control=3, pc_src=1.
  - pc_write = (beq & zero) | (bne & ~zero).
  - Pulses retire, then goes to FETCH.
- JUMP:
  - Drives pc_write=1, pc_src=2.
  - For jal, also drives link=1 and reg_write=1.
  - Pulses retire, then goes to FETCH.
- instr_count increments by 1 on every retire pulse and wraps modulo 2^CNT_W.

## Timing
- Outputs are decoded combinationally from the registered state and registered class. They never depend on opcode outside DECODE.
- Reset assertion takes effect immediately and asynchronously:
  - state goes to RESET and instr_count goes to 0.
  - An in-flight memory access is abandoned: mem_read and mem_write drop in the same cycle.
- The first rising edge after reset deasserts enters FETCH.
- Cycle counts with zero memory wait (mem_ready=1):
  - R-type and I-arith: 4.
  - lw: 5.
  - sw: 4.
  - beq, bne, j, jal: 3.
  - illegal: 2.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. While waiting, pc_write and ir_write stay 0.
- retire and illegal are asserted for exactly one cycle per instruction.
- instr_count shows the incremented value in the cycle after retire.

## Test plan
- Reset low mid-MEM_READ -> state=0, all outputs 0, instr_count=0 immediately. After release: one RESET cycle, then FETCH with mem_read=1.
- add (opcode 0, funct 0x20), mem_ready=1 -> states 1, 2, 7, 9. reg_write=1 and reg_dst=1 in ALU_WB. instr_count goes 0 to 1 after 4 cycles.
- lw, mem_ready held low 3 cycles in MEM_READ -> 8 cycles total. mem_to_reg=1, reg_write=1 only in MEM_WB.
- beq with zero=1 -> pc_write=1, pc_src=1 in BRANCH. Same with zero=0 -> pc_write=0. bne gives the inverse result.
- jal with ENABLE_JAL=1 -> link=1, reg_write=1, pc_src=2. With ENABLE_JAL=0 -> illegal pulses in DECODE, no reg_write, 2 cycles.
- Retire 2^CNT_W instructions with CNT_W=4 -> instr_count wraps from 15 to 0. andi -> alu_control=5, ext_zero=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: walks each instruction through fetch, decode, execute,
// memory and write-back states, with ready-handshaked memory and a retire counter.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 32,
    parameter bit ENABLE_JAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  link,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic                  ext_zero,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal,
    output logic                  retire,
    output logic [3:0]            state,
    output logic [CNT_W-1:0]      instr_count
);
    typedef enum logic [3:0] {
        S_RESET = 4'd0, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
        S_MEM_WRITE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0, OP_SLL, OP_ADD, OP_SUB, OP_OR, OP_ADDI, OP_ANDI, OP_ORI,
        OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL
    } op_e;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] ALU_LUI = ALU_CTRL_W'(12);

    state_e            state_q, state_d;
    op_e               op_q, op_d, dec_op;
    logic              reg_dst_q, reg_dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Opcode/funct are only looked at here; later states run off the registered op.
    always_comb begin
        dec_op = OP_NONE;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00:   dec_op = OP_SLL;
                    6'h20:   dec_op = OP_ADD;
                    6'h22:   dec_op = OP_SUB;
                    6'h25:   dec_op = OP_OR;
                    default: dec_op = OP_NONE;
                endcase
            end
            6'h23:   dec_op = OP_LW;
            6'h2B:   dec_op = OP_SW;
            6'h08:   dec_op = OP_ADDI;
            6'h0C:   dec_op = OP_ANDI;
            6'h0D:   dec_op = OP_ORI;
            6'h0F:   dec_op = OP_LUI;
            6'h04:   dec_op = OP_BEQ;
            6'h05:   dec_op = OP_BNE;
            6'h02:   dec_op = OP_J;
            6'h03:   dec_op = ENABLE_JAL ? OP_JAL : OP_NONE;
            default: dec_op = OP_NONE;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        reg_dst_d   = reg_dst_q;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        link        = 1'b0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        ext_zero    = 1'b0;
        alu_control = '0;
        illegal     = 1'b0;
        retire      = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_read    = 1'b1;
                alu_src_b   = 2'd1;
                alu_control = ALU_ADD;
                ir_write    = mem_ready;
                pc_write    = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b   = 2'd3;
                alu_control = ALU_ADD;
                op_d        = dec_op;
                reg_dst_d   = (opcode == 6'h00);
                case (dec_op)
                    OP_SLL, OP_ADD, OP_SUB, OP_OR:    state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                    OP_J, OP_JAL:                     state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = (op_q == OP_SLL) ? 2'd2 : 2'd1;
                case (op_q)
                    OP_SLL:  alu_control = ALU_SLL;
                    OP_SUB:  alu_control = ALU_SUB;
                    OP_OR:   alu_control = ALU_OR;
                    default: alu_control = ALU_ADD;
                endcase
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                case (op_q)
                    OP_ANDI: begin alu_control = ALU_AND; ext_zero = 1'b1; end
                    OP_ORI:  begin alu_control = ALU_OR;  ext_zero = 1'b1; end
                    OP_LUI:  alu_control = ALU_LUI;
                    default: alu_control = ALU_ADD;
                endcase
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = reg_dst_q;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a   = 2'd1;
                alu_src_b   = 2'd2;
                alu_control = ALU_ADD;
                state_d     = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a   = 2'd1;
                alu_control = ALU_SUB;
                pc_src      = 2'd1;
                pc_write    = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_src    = 2'd2;
                link      = (op_q == OP_JAL);
                reg_write = (op_q == OP_JAL);
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign cnt_d = cnt_q + CNT_W'(retire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RESET;
            op_q      <= OP_NONE;
            reg_dst_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            reg_dst_q <= reg_dst_d;
            cnt_q     <= cnt_d;
        end
    end

    assign state       = state_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: instance a uses default parameters,
// instance b has CNT_W=4 and jal disabled.
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       rst_a, rst_b, zero, mem_ready;
    logic [5:0] opcode, funct;
    int         vecs = 0;
    int         errs = 0;
    int         exp_cnt = 0;

    logic a_pc_write, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg;
    logic a_reg_write, a_link, a_ext_zero, a_illegal, a_retire;
    logic [1:0] a_pc_src, a_alu_src_a, a_alu_src_b;
    logic [3:0] a_alu_control, a_state;
    logic [31:0] a_instr_count;
    logic b_pc_write, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg;
    logic b_reg_write, b_link, b_ext_zero, b_illegal, b_retire;
    logic [1:0] b_pc_src, b_alu_src_a, b_alu_src_b;
    logic [3:0] b_alu_control, b_state;
    logic [3:0] b_instr_count;
    logic [25:0] a_vec, b_vec;

    assign a_vec = {a_pc_write, a_pc_src, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst,
                    a_mem_to_reg, a_reg_write, a_link, a_alu_src_a, a_alu_src_b, a_ext_zero,
                    a_alu_control, a_illegal, a_retire, a_state};
    assign b_vec = {b_pc_write, b_pc_src, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst,
                    b_mem_to_reg, b_reg_write, b_link, b_alu_src_a, b_alu_src_b, b_ext_zero,
                    b_alu_control, b_illegal, b_retire, b_state};

    multicycle_control_unit dut_a (
        .clk(clk), .reset(rst_a), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(a_pc_write), .pc_src(a_pc_src), .iord(a_iord),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .ir_write(a_ir_write),
        .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write),
        .link(a_link), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .ext_zero(a_ext_zero), .alu_control(a_alu_control), .illegal(a_illegal),
        .retire(a_retire), .state(a_state), .instr_count(a_instr_count)
    );

    multicycle_control_unit #(.CNT_W(4), .ENABLE_JAL(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(b_pc_write), .pc_src(b_pc_src), .iord(b_iord),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
        .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
        .link(b_link), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .ext_zero(b_ext_zero), .alu_control(b_alu_control), .illegal(b_illegal),
        .retire(b_retire), .state(b_state), .instr_count(b_instr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if ({a_vec, a_instr_count, b_vec, b_instr_count} !== '0) begin
            errs++; $display("FAIL reset_outputs got a=%h b=%h cnt=%0d want all zero", a_vec, b_vec, a_instr_count);
        end
        rst_a = 1'b1; mem_ready = 1'b1; #1;
        vecs++;
        if (a_vec !== 26'd0) begin errs++; $display("FAIL reset_release got %h want 0", a_vec); end
        step(); #1;
        vecs++;
        if ({a_state, a_mem_read, a_iord, a_alu_src_b, a_alu_control, a_ir_write} !== {4'd1, 1'b1, 1'b0, 2'd1, 4'd2, 1'b1}) begin
            errs++; $display("FAIL reset_first_fetch got %h want %h",
                {a_state, a_mem_read, a_iord, a_alu_src_b, a_alu_control, a_ir_write}, {4'd1, 1'b1, 1'b0, 2'd1, 4'd2, 1'b1});
        end
    endtask

    task automatic test_add();
        opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1; #1;
        vecs++;
        if ({a_state, a_ir_write, a_pc_write, a_pc_src} !== {4'd1, 1'b1, 1'b1, 2'd0}) begin
            errs++; $display("FAIL add_fetch got %h want %h", {a_state, a_ir_write, a_pc_write, a_pc_src}, {4'd1, 1'b1, 1'b1, 2'd0});
        end
        step(); #1;
        vecs++;
        if ({a_state, a_alu_src_a, a_alu_src_b, a_alu_control, a_retire} !== {4'd2, 2'd0, 2'd3, 4'd2, 1'b0}) begin
            errs++; $display("FAIL add_decode got %h want %h", {a_state, a_alu_src_a, a_alu_src_b, a_alu_control, a_retire}, {4'd2, 2'd0, 2'd3, 4'd2, 1'b0});
        end
        step(); #1;
        vecs++;
        if ({a_state, a_alu_src_a, a_alu_src_b, a_alu_control} !== {4'd7, 2'd1, 2'd0, 4'd2}) begin
            errs++; $display("FAIL add_exec got %h want %h", {a_state, a_alu_src_a, a_alu_src_b, a_alu_control}, {4'd7, 2'd1, 2'd0, 4'd2});
        end
        step(); #1;
        vecs++;
        if ({a_state, a_reg_write, a_reg_dst, a_retire, a_instr_count} !== {4'd9, 1'b1, 1'b1, 1'b1, 32'd0}) begin
            errs++; $display("FAIL add_wb got %h want %h", {a_state, a_reg_write, a_reg_dst, a_retire, a_instr_count}, {4'd9, 1'b1, 1'b1, 1'b1, 32'd0});
        end
        step(); #1;
        exp_cnt = 1;
        vecs++;
        if ({a_state, a_retire, a_instr_count} !== {4'd1, 1'b0, 32'd1}) begin
            errs++; $display("FAIL add_count got %h want %h", {a_state, a_retire, a_instr_count}, {4'd1, 1'b0, 32'd1});
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn [3];
        logic [1:0] sa [3];
        logic [3:0] ac [3];
        fn = '{6'h00, 6'h22, 6'h25};
        sa = '{2'd2, 2'd1, 2'd1};
        ac = '{4'd8, 4'd3, 4'd6};
        for (int i = 0; i < 3; i++) begin
            opcode = 6'h00; funct = fn[i];
            mem_ready = (i != 0); #1;
            if (i == 0) begin
                vecs++;
                if ({a_state, a_ir_write, a_pc_write, a_mem_read} !== {4'd1, 1'b0, 1'b0, 1'b1}) begin
                    errs++; $display("FAIL fetch_wait got %h want %h", {a_state, a_ir_write, a_pc_write, a_mem_read}, {4'd1, 1'b0, 1'b0, 1'b1});
                end
                step(); mem_ready = 1'b1; #1;
            end
            step(); step(); #1;
            vecs++;
            if ({a_state, a_alu_src_a, a_alu_src_b, a_alu_control} !== {4'd7, sa[i], 2'd0, ac[i]}) begin
                errs++; $display("FAIL rtype_exec funct=%h got %h want %h", fn[i], {a_state, a_alu_src_a, a_alu_src_b, a_alu_control}, {4'd7, sa[i], 2'd0, ac[i]});
            end
            step(); step(); #1;
            exp_cnt++;
            vecs++;
            if ({a_state, a_instr_count} !== {4'd1, 32'(exp_cnt)}) begin
                errs++; $display("FAIL rtype_count got %h want %h", {a_state, a_instr_count}, {4'd1, 32'(exp_cnt)});
            end
        end
    endtask

    task automatic test_lw_wait();
        int cyc;
        opcode = 6'h23; mem_ready = 1'b1; #1;
        cyc = 1;
        step(); step(); #1; cyc += 2;
        vecs++;
        if ({a_state, a_alu_src_a, a_alu_src_b, a_alu_control} !== {4'd3, 2'd1, 2'd2, 4'd2}) begin
            errs++; $display("FAIL lw_addr got %h want %h", {a_state, a_alu_src_a, a_alu_src_b, a_alu_control}, {4'd3, 2'd1, 2'd2, 4'd2});
        end
        for (int i = 0; i < 4; i++) begin
            step(); mem_ready = (i == 3); #1; cyc++;
            vecs++;
            if ({a_state, a_mem_read, a_iord, a_reg_write, a_mem_to_reg} !== {4'd4, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                errs++; $display("FAIL lw_read cyc=%0d got %h want %h", cyc, {a_state, a_mem_read, a_iord, a_reg_write, a_mem_to_reg}, {4'd4, 1'b1, 1'b1, 1'b0, 1'b0});
            end
        end
        step(); #1; cyc++;
        vecs++;
        if ({a_state, a_reg_write, a_mem_to_reg, a_reg_dst, a_retire} !== {4'd5, 1'b1, 1'b1, 1'b0, 1'b1} || cyc != 8) begin
            errs++; $display("FAIL lw_wb cyc=%0d got %h want %h", cyc, {a_state, a_reg_write, a_mem_to_reg, a_reg_dst, a_retire}, {4'd5, 1'b1, 1'b1, 1'b0, 1'b1});
        end
        step(); #1;
        exp_cnt++;
        vecs++;
        if ({a_state, a_instr_count} !== {4'd1, 32'(exp_cnt)}) begin
            errs++; $display("FAIL lw_count got %h want %h", {a_state, a_instr_count}, {4'd1, 32'(exp_cnt)});
        end
    endtask

    task automatic test_sw();
        opcode = 6'h2B; mem_ready = 1'b1; #1;
        step(); step(); step(); #1;
        vecs++;
        if ({a_state, a_mem_write, a_iord, a_mem_read, a_retire} !== {4'd6, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            errs++; $display("FAIL sw_write got %h want %h", {a_state, a_mem_write, a_iord, a_mem_read, a_retire}, {4'd6, 1'b1, 1'b1, 1'b0, 1'b1});
        end
        step(); #1;
        exp_cnt++;
        vecs++;
        if ({a_state, a_instr_count} !== {4'd1, 32'(exp_cnt)}) begin
            errs++; $display("FAIL sw_count got %h want %h", {a_state, a_instr_count}, {4'd1, 32'(exp_cnt)});
        end
    endtask

    task automatic test_branch();
        logic [5:0] op [4];
        logic       z [4];
        logic       pw [4];
        op = '{6'h04, 6'h04, 6'h05, 6'h05};
        z  = '{1'b1, 1'b0, 1'b1, 1'b0};
        pw = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            opcode = op[i]; zero = z[i]; mem_ready = 1'b1; #1;
            step(); step(); #1;
            vecs++;
            if ({a_state, a_pc_write, a_pc_src, a_alu_src_a, a_alu_src_b, a_alu_control, a_retire} !==
                {4'd10, pw[i], 2'd1, 2'd1, 2'd0, 4'd3, 1'b1}) begin
                errs++; $display("FAIL branch op=%h zero=%0d got %h want %h", op[i], z[i],
                    {a_state, a_pc_write, a_pc_src, a_alu_src_a, a_alu_src_b, a_alu_control, a_retire},
                    {4'd10, pw[i], 2'd1, 2'd1, 2'd0, 4'd3, 1'b1});
            end
            step(); #1;
            exp_cnt++;
            vecs++;
            if ({a_state, a_instr_count} !== {4'd1, 32'(exp_cnt)}) begin
                errs++; $display("FAIL branch_count got %h want %h", {a_state, a_instr_count}, {4'd1, 32'(exp_cnt)});
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [5:0] op [2];
        logic       lk [2];
        op = '{6'h03, 6'h02};
        lk = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            opcode = op[i]; mem_ready = 1'b1; #1;
            step(); step(); #1;
            vecs++;
            if ({a_state, a_pc_write, a_pc_src, a_link, a_reg_write, a_retire} !== {4'd11, 1'b1, 2'd2, lk[i], lk[i], 1'b1}) begin
                errs++; $display("FAIL jump op=%h got %h want %h", op[i], {a_state, a_pc_write, a_pc_src, a_link, a_reg_write, a_retire},
                    {4'd11, 1'b1, 2'd2, lk[i], lk[i], 1'b1});
            end
            step(); #1;
            exp_cnt++;
            vecs++;
            if ({a_state, a_instr_count} !== {4'd1, 32'(exp_cnt)}) begin
                errs++; $display("FAIL jump_count got %h want %h", {a_state, a_instr_count}, {4'd1, 32'(exp_cnt)});
            end
        end
    endtask

    task automatic test_itype();
        logic [5:0] op [4];
        logic [3:0] ac [4];
        logic       ez [4];
        op = '{6'h08, 6'h0C, 6'h0D, 6'h0F};
        ac = '{4'd2, 4'd5, 4'd6, 4'd12};
        ez = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            opcode = op[i]; mem_ready = 1'b1; #1;
            step(); step(); #1;
            vecs++;
            if ({a_state, a_alu_src_a, a_alu_src_b, a_alu_control, a_ext_zero} !== {4'd8, 2'd1, 2'd2, ac[i], ez[i]}) begin
                errs++; $display("FAIL itype_exec op=%h got %h want %h", op[i], {a_state, a_alu_src_a, a_alu_src_b, a_alu_control, a_ext_zero},
                    {4'd8, 2'd1, 2'd2, ac[i], ez[i]});
            end
            step(); #1;
            vecs++;
            if ({a_state, a_reg_write, a_reg_dst, a_retire} !== {4'd9, 1'b1, 1'b0, 1'b1}) begin
                errs++; $display("FAIL itype_wb got %h want %h", {a_state, a_reg_write, a_reg_dst, a_retire}, {4'd9, 1'b1, 1'b0, 1'b1});
            end
            step(); #1;
            exp_cnt++;
        end
        vecs++;
        if ({a_state, a_instr_count} !== {4'd1, 32'(exp_cnt)}) begin
            errs++; $display("FAIL itype_count got %h want %h", {a_state, a_instr_count}, {4'd1, 32'(exp_cnt)});
        end
    endtask

    task automatic test_illegal();
        logic [5:0] op [2];
        logic [5:0] fn [2];
        op = '{6'h3F, 6'h00};
        fn = '{6'h20, 6'h01};
        for (int i = 0; i < 2; i++) begin
            opcode = op[i]; funct = fn[i]; mem_ready = 1'b1; #1;
            step(); #1;
            vecs++;
            if ({a_state, a_illegal, a_retire, a_reg_write} !== {4'd2, 1'b1, 1'b1, 1'b0}) begin
                errs++; $display("FAIL illegal op=%h fn=%h got %h want %h", op[i], fn[i], {a_state, a_illegal, a_retire, a_reg_write}, {4'd2, 1'b1, 1'b1, 1'b0});
            end
            step(); #1;
            exp_cnt++;
            vecs++;
            if ({a_state, a_illegal, a_instr_count} !== {4'd1, 1'b0, 32'(exp_cnt)}) begin
                errs++; $display("FAIL illegal_count got %h want %h", {a_state, a_illegal, a_instr_count}, {4'd1, 1'b0, 32'(exp_cnt)});
            end
        end
    endtask

    task automatic test_reset_midflight();
        opcode = 6'h23; mem_ready = 1'b1; #1;
        step(); step(); mem_ready = 1'b0;
        step(); #1;
        vecs++;
        if ({a_state, a_mem_read} !== {4'd4, 1'b1}) begin
            errs++; $display("FAIL mid_read got %h want %h", {a_state, a_mem_read}, {4'd4, 1'b1});
        end
        step(); rst_a = 1'b0; #1;
        exp_cnt = 0;
        vecs++;
        if ({a_vec, a_instr_count} !== '0) begin
            errs++; $display("FAIL mid_reset got vec=%h cnt=%0d want 0", a_vec, a_instr_count);
        end
        step(); rst_a = 1'b1; #1;
        vecs++;
        if ({a_state, a_mem_read} !== {4'd0, 1'b0}) begin
            errs++; $display("FAIL mid_release got %h want %h", {a_state, a_mem_read}, {4'd0, 1'b0});
        end
        step(); #1;
        vecs++;
        if ({a_state, a_mem_read, a_pc_write, a_instr_count} !== {4'd1, 1'b1, 1'b0, 32'd0}) begin
            errs++; $display("FAIL mid_refetch got %h want %h", {a_state, a_mem_read, a_pc_write, a_instr_count}, {4'd1, 1'b1, 1'b0, 32'd0});
        end
    endtask

    task automatic test_jal_disabled();
        opcode = 6'h03; mem_ready = 1'b1; rst_b = 1'b1; #1;
        vecs++;
        if (b_state !== 4'd0) begin errs++; $display("FAIL nojal_reset got %0d want 0", b_state); end
        step(); #1;
        vecs++;
        if ({b_state, b_mem_read} !== {4'd1, 1'b1}) begin
            errs++; $display("FAIL nojal_fetch got %h want %h", {b_state, b_mem_read}, {4'd1, 1'b1});
        end
        step(); #1;
        vecs++;
        if ({b_state, b_illegal, b_retire, b_reg_write, b_link} !== {4'd2, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errs++; $display("FAIL nojal_decode got %h want %h", {b_state, b_illegal, b_retire, b_reg_write, b_link}, {4'd2, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        step(); #1;
        vecs++;
        if ({b_state, b_illegal, b_instr_count} !== {4'd1, 1'b0, 4'd1}) begin
            errs++; $display("FAIL nojal_count got %h want %h", {b_state, b_illegal, b_instr_count}, {4'd1, 1'b0, 4'd1});
        end
    endtask

    task automatic test_wrap();
        opcode = 6'h3F; mem_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(); step();
        end
        #1;
        vecs++;
        if ({b_state, b_instr_count} !== {4'd1, 4'd15}) begin
            errs++; $display("FAIL wrap_15 got %h want %h", {b_state, b_instr_count}, {4'd1, 4'd15});
        end
        step(); #1;
        vecs++;
        if ({b_state, b_retire, b_instr_count} !== {4'd2, 1'b1, 4'd15}) begin
            errs++; $display("FAIL wrap_retire got %h want %h", {b_state, b_retire, b_instr_count}, {4'd2, 1'b1, 4'd15});
        end
        step(); #1;
        vecs++;
        if ({b_state, b_instr_count} !== {4'd1, 4'd0}) begin
            errs++; $display("FAIL wrap_0 got %h want %h", {b_state, b_instr_count}, {4'd1, 4'd0});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jump();
        test_itype();
        test_illegal();
        test_reset_midflight();
        test_jal_disabled();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
